// File: rtl/clock_div_ctrl_if.sv
// Request/status bundle between a divisor requester (master) and clock_div_ctrl (slave).
// Handshake: a request transfers on a clock edge where req_valid && req_ready; the master
// holds req_valid and req_div stable until that edge, and req_valid is ignored otherwise.
interface clock_div_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             req_valid;
  logic [WIDTH-1:0] req_div;
  logic             req_ready;
  logic             done;
  logic             clamped;
  logic             busy;
  logic [WIDTH-1:0] div_num;
  logic             div_reset;
  logic [1:0]       dbg_state;

  modport master (
    output req_valid, req_div,
    input  req_ready, done, clamped, busy, div_num, div_reset, dbg_state
  );

  modport slave (
    input  req_valid, req_div,
    output req_ready, done, clamped, busy, div_num, div_reset, dbg_state
  );
endinterface

// File: rtl/clock_div_ctrl.sv
// Divisor owner for clock_div: swaps div_num only while the divider is held in reset,
// then releases it, waits a settle window and pulses done. All outputs are registered.
module clock_div_ctrl #(
  parameter int WIDTH         = 8,
  parameter int DEFAULT_DIV   = 1,
  parameter int MIN_DIV       = 0,
  parameter int HOLD_CYCLES   = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk_in,
  input  logic             reset_n,
  clock_div_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_IDLE   = 2'd1,
    S_HOLD   = 2'd2,
    S_SETTLE = 2'd3
  } state_e;

  localparam int CNT_MAX = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0]    HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]    SETTLE_LAST = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [WIDTH-1:0] DEF_V       = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] MIN_V       = WIDTH'(MIN_DIV);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             upd_q, upd_d;
  logic             clamp_q, clamp_d;
  logic             done_q, done_d;
  logic             clamped_q, clamped_d;
  logic             ready_q, busy_q, rst_q;
  logic             req_low;
  logic [WIDTH-1:0] eff;

  // With MIN_DIV = 0 no request can be below the floor, so skip the always-false compare.
  if (MIN_DIV > 0) begin : g_clamp
    assign req_low = (bus.req_div < MIN_V);
  end else begin : g_no_clamp
    assign req_low = 1'b0;
  end
  assign eff = req_low ? MIN_V : bus.req_div;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    upd_d     = upd_q;
    clamp_d   = clamp_q;
    done_d    = 1'b0;
    clamped_d = 1'b0;
    case (state_q)
      S_INIT: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = (SETTLE_CYCLES == 0) ? S_IDLE : S_SETTLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_IDLE: begin
        if (bus.req_valid && ready_q) begin
          if (eff == div_q) begin
            done_d    = 1'b1;
            clamped_d = req_low;
          end else begin
            div_d   = eff;
            upd_d   = 1'b1;
            clamp_d = req_low;
            cnt_d   = '0;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d = '0;
          if (SETTLE_CYCLES == 0) begin
            state_d   = S_IDLE;
            done_d    = upd_q;
            clamped_d = upd_q & clamp_q;
            upd_d     = 1'b0;
          end else begin
            state_d = S_SETTLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SETTLE: begin
        // Settle after INIT has no pending update, so it returns to IDLE silently.
        if (cnt_q == SETTLE_LAST) begin
          cnt_d     = '0;
          state_d   = S_IDLE;
          done_d    = upd_q;
          clamped_d = upd_q & clamp_q;
          upd_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_INIT;
      cnt_q     <= '0;
      div_q     <= DEF_V;
      upd_q     <= 1'b0;
      clamp_q   <= 1'b0;
      done_q    <= 1'b0;
      clamped_q <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b1;
      rst_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      upd_q     <= upd_d;
      clamp_q   <= clamp_d;
      done_q    <= done_d;
      clamped_q <= clamped_d;
      ready_q   <= (state_d == S_IDLE);
      busy_q    <= (state_d != S_IDLE);
      rst_q     <= (state_d == S_INIT) || (state_d == S_HOLD);
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.done      = done_q;
  assign bus.clamped   = clamped_q;
  assign bus.busy      = busy_q;
  assign bus.div_num   = div_q;
  assign bus.div_reset = rst_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_clock_div_ctrl.sv
// Bench for clock_div_ctrl: two instances (MIN_DIV 0 and 3) share stimulus and are
// compared every cycle against a per-cycle output timeline built from the request rules.
module tb_clock_div_ctrl;
  localparam int W     = 8;
  localparam int EW    = W + 5;
  localparam int H     = 2;
  localparam int S     = 4;
  localparam int DEF   = 1;
  localparam int MIN0  = 0;
  localparam int MIN1  = 3;

  logic         clk_in = 1'b0;
  logic         reset_n = 1'b0;
  logic         req_valid = 1'b0;
  logic [W-1:0] req_div = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  string phase = "init";

  // Expected outputs per cycle, packed {req_ready, busy, div_reset, done, clamped, div_num}
  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] last_e[2];
  int            cur[2];
  bit            accepted[2];

  clock_div_ctrl_if #(.WIDTH(W)) if0 ();
  clock_div_ctrl_if #(.WIDTH(W)) if1 ();

  assign if0.req_valid = req_valid;
  assign if0.req_div   = req_div;
  assign if1.req_valid = req_valid;
  assign if1.req_div   = req_div;

  clock_div_ctrl #(.WIDTH(W), .DEFAULT_DIV(DEF), .MIN_DIV(MIN0),
                   .HOLD_CYCLES(H), .SETTLE_CYCLES(S)) dut0 (
    .clk_in (clk_in),
    .reset_n(reset_n),
    .bus    (if0.slave)
  );

  clock_div_ctrl #(.WIDTH(W), .DEFAULT_DIV(DEF), .MIN_DIV(MIN1),
                   .HOLD_CYCLES(H), .SETTLE_CYCLES(S)) dut1 (
    .clk_in (clk_in),
    .reset_n(reset_n),
    .bus    (if1.slave)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [EW-1:0] pack(input logic r, input logic b, input logic dr,
                                         input logic dn, input logic cl, input int dv);
    return {r, b, dr, dn, cl, W'(dv)};
  endfunction

  function automatic logic [EW-1:0] actual(input int d);
    if (d == 0)
      return {if0.req_ready, if0.busy, if0.div_reset, if0.done, if0.clamped, if0.div_num};
    return {if1.req_ready, if1.busy, if1.div_reset, if1.done, if1.clamped, if1.div_num};
  endfunction

  task automatic compare(input int d, input logic [EW-1:0] e, input string what);
    logic [EW-1:0] a;
    a = actual(d);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s/%s dut%0d cycle %0d: got rdy/busy/rst/done/clamp=%b div=%0d, want %b div=%0d",
               phase, what, d, cyc, a[EW-1:W], a[W-1:0], e[EW-1:W], e[W-1:0]);
    end
  endtask

  // Model: an accepted request expands into the full output timeline that follows it.
  task automatic plan(input int d);
    int mn;
    int eff;
    bit cl;
    logic [EW-1:0] burst[$];
    if (!(last_e[d][EW-1] && req_valid)) return;
    mn  = (d == 0) ? MIN0 : MIN1;
    cl  = (int'(req_div) < mn);
    eff = cl ? mn : int'(req_div);
    accepted[d] = 1'b1;
    if (eff == cur[d]) begin
      burst.push_back(pack(1, 0, 0, 1, cl, eff));
    end else begin
      cur[d] = eff;
      for (int i = 0; i < H; i++) burst.push_back(pack(0, 1, 1, 0, 0, eff));
      for (int i = 0; i < S; i++) burst.push_back(pack(0, 1, 0, 0, 0, eff));
      burst.push_back(pack(1, 0, 0, 1, cl, eff));
    end
    foreach (burst[i]) begin
      if (d == 0) exp_q0.push_back(burst[i]);
      else        exp_q1.push_back(burst[i]);
    end
  endtask

  task automatic tick();
    logic [EW-1:0] e0, e1;
    plan(0);
    plan(1);
    @(negedge clk_in);
    cyc++;
    e0 = (exp_q0.size() > 0) ? exp_q0.pop_front() : pack(1, 0, 0, 0, 0, cur[0]);
    e1 = (exp_q1.size() > 0) ? exp_q1.pop_front() : pack(1, 0, 0, 0, 0, cur[1]);
    compare(0, e0, "cycle");
    compare(1, e1, "cycle");
    last_e[0] = e0;
    last_e[1] = e1;
  endtask

  // Asserts reset asynchronously mid-phase, checks reset values, then releases it.
  task automatic do_reset();
    logic [EW-1:0] r;
    r = pack(0, 1, 1, 0, 0, DEF);
    @(negedge clk_in);
    #2;
    reset_n = 1'b0;
    #1;
    compare(0, r, "reset_assert");
    compare(1, r, "reset_assert");
    exp_q0.delete();
    exp_q1.delete();
    repeat (3) @(negedge clk_in);
    req_valid = 1'b0;
    reset_n = 1'b1;
    #1;
    compare(0, r, "reset_release");
    compare(1, r, "reset_release");
    for (int d = 0; d < 2; d++) begin
      cur[d]    = DEF;
      last_e[d] = r;
    end
    for (int i = 0; i < H - 1; i++) begin
      exp_q0.push_back(r);
      exp_q1.push_back(r);
    end
    for (int i = 0; i < S; i++) begin
      exp_q0.push_back(pack(0, 1, 0, 0, 0, DEF));
      exp_q1.push_back(pack(0, 1, 0, 0, 0, DEF));
    end
  endtask

  task automatic request(input logic [W-1:0] d);
    int n;
    n = 0;
    accepted[0] = 1'b0;
    accepted[1] = 1'b0;
    req_valid = 1'b1;
    req_div   = d;
    while (!(accepted[0] && accepted[1]) && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (!(accepted[0] && accepted[1])) begin
      errors++;
      $display("FAIL %s/accept_timeout: req_div=%0d accepted=%0b%0b after %0d cycles, want both",
               phase, d, accepted[1], accepted[0], n);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    phase = "reset";
    do_reset();
    repeat (H + S + 3) tick();
  endtask

  task automatic test_update();
    phase = "update";
    request(8'd5);
    repeat (H + S + 3) tick();
  endtask

  task automatic test_same_div();
    phase = "same_div";
    request(8'd5);
    repeat (3) tick();
  endtask

  task automatic test_clamp();
    phase = "clamp";
    request(8'd1);
    repeat (H + S + 3) tick();
    request(8'd0);
    repeat (H + S + 3) tick();
  endtask

  task automatic test_held_during_busy();
    phase = "held_busy";
    request(8'd6);
    request(8'd9);
    repeat (H + S + 3) tick();
  endtask

  task automatic test_back_to_back();
    phase = "back_to_back";
    request(8'd9);
    req_valid = 1'b1;
    repeat (4) tick();
    req_valid = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset_abort();
    phase = "reset_abort";
    request(8'd5);
    repeat (H + S + 2) tick();
    request(8'd7);
    repeat (H + 1) tick();
    do_reset();
    repeat (H + S + 3) tick();
  endtask

  task automatic test_random();
    phase = "random";
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      request(W'($urandom_range(0, 12)));
    end
    repeat (H + S + 3) tick();
  endtask

  initial begin
    test_reset();
    test_update();
    test_same_div();
    test_clamp();
    test_held_during_busy();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
